// File: rtl/rr_dec_arbiter16_pkg.sv
// Shared constants, FSM state type and the first-set-bit scan helper
// for the 16-way round-robin arbiter.
package arb_pkg;
  localparam int N      = 16;
  localparam int IDX_W  = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Lowest set bit of v as {found, index}; found=0 means v is all zero.
  function automatic logic [IDX_W:0] first_set(input logic [N-1:0] v);
    first_set = '0;
    for (int i = N-1; i >= 0; i--)
      if (v[i]) first_set = {1'b1, IDX_W'(i)};
  endfunction
endpackage

// File: rtl/rr_dec_arbiter16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_dec_arbiter16_if;
  import arb_pkg::*;

  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout_err;

  modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout_err);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, timeout_err);
endinterface

// File: rtl/rr_dec_arbiter16_onehot_dec4x16.sv
// 4-bit index to 16-bit one-hot with enable. Two levels of 2-to-4 decode:
// idx[3:2] selects a group of four, idx[1:0] selects the bit within it.
module onehot_dec4x16 (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);
  logic [3:0] grp;
  logic [3:0] bit_sel;

  assign grp     = {4{en}} & (4'b0001 << idx[3:2]);
  assign bit_sel = 4'b0001 << idx[1:0];

  for (genvar g = 0; g < 4; g++) begin : g_grp
    assign onehot[4*g +: 4] = {4{grp[g]}} & bit_sel;
  end
endmodule

// File: rtl/rr_dec_arbiter16.sv
// 16-requester round-robin arbiter. A grant is held until the owner pulses
// done or drops its request; the pointer then moves past the owner and one
// IDLE cycle separates consecutive grants.
// Build option: define ARB_TIMEOUT_EN to force release after HOLD_MAX BUSY
// cycles, flagged by a one-cycle timeout_err pulse.
module rr_dec_arbiter16
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_dec_arbiter16_if.slave bus
);
  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [2*N-1:0]   req2;
  logic [N-1:0]     rot;
  logic [IDX_W:0]   scan;
  logic             rel_own;
  logic             tmo;
  logic             gnt_vld;

  // Rotate so bit 0 is the requester at ptr; the winner is ptr + offset mod 16.
  assign req2    = {bus.req, bus.req};
  assign rot     = req2[{1'b0, ptr} +: N];
  assign scan    = first_set(rot);
  assign rel_own = bus.done | ~bus.req[idx];

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              terr;

  assign tmo             = (hold_cnt == HOLD_LAST);
  assign bus.timeout_err = terr;

  // Count BUSY cycles; held at zero in IDLE so each grant starts fresh.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              hold_cnt <= '0;
    else if (state == BUSY)  hold_cnt <= hold_cnt + 1'b1;
    else                     hold_cnt <= '0;

  // Flag forced release only; a done/withdraw on the same cycle wins.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) terr <= 1'b0;
    else        terr <= (state == BUSY) && tmo && !rel_own;
`else
  assign tmo = 1'b0;
  // HOLD_MAX only matters with the timeout; its legal range (>=1) keeps this 0.
  assign bus.timeout_err = (HOLD_MAX == 0);
`endif

  // Next state: pick a winner from IDLE, release and advance ptr from BUSY.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    case (state)
      IDLE: if (scan[IDX_W]) begin
        state_nxt = BUSY;
        idx_nxt   = ptr + scan[IDX_W-1:0];
      end
      BUSY: if (rel_own || tmo) begin
        state_nxt = IDLE;
        ptr_nxt   = idx + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer and grant index registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
    end

  assign gnt_vld     = (state == BUSY);
  assign bus.gnt_vld = gnt_vld;
  assign bus.gnt_idx = idx;

  onehot_dec4x16 u_dec (
    .idx    (idx),
    .en     (gnt_vld),
    .onehot (bus.gnt)
  );
endmodule
